// File: rtl/uart_cmd_responder.sv
// uart_cmd_responder
// Far-end responder for the host serial link. Parses single-byte read/write
// commands from the UART receiver byte stream, executes them on an 8-bit
// register bus and returns exactly one response byte to the UART transmitter.
//
//   Write : 'W'(0x57) addr data -> reply 'K'(0x4B)
//   Read  : 'R'(0x52) addr      -> reply read byte, or 'T'(0x54) on bus timeout
//   Other first byte            -> reply '?'(0x3F)
//
// Ports
//   clk, rst                    clock, asynchronous active-high reset
//   rx_data, rx_data_fresh      received byte and its one-cycle valid pulse
//   tx_data, tx_data_valid      response byte, held until tx_data_ack
//   tx_data_ack                 transmitter accepted the byte (one-cycle pulse)
//   reg_addr, reg_wdata         register bus address / write data
//   reg_we, reg_re              one-cycle write / read strobes
//   reg_rdata, reg_rdy          read data and its valid flag
//   busy                        high whenever a command is in progress
//   cmd_overrun                 sticky: byte arrived while not accepting
module uart_cmd_responder #(
  parameter int unsigned IDLE_TIMEOUT = 5_000_000,
  parameter int unsigned RD_TIMEOUT   = 256
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_data_fresh,
  output logic [7:0] tx_data,
  output logic       tx_data_valid,
  input  logic       tx_data_ack,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_we,
  output logic       reg_re,
  input  logic [7:0] reg_rdata,
  input  logic       reg_rdy,
  output logic       busy,
  output logic       cmd_overrun
);

  localparam logic [7:0] CMD_WR  = 8'h57;
  localparam logic [7:0] CMD_RD  = 8'h52;
  localparam logic [7:0] RSP_OK  = 8'h4B;
  localparam logic [7:0] RSP_TO  = 8'h54;
  localparam logic [7:0] RSP_UNK = 8'h3F;

  // Terminal counts: the timer value on which the timeout fires.
  localparam logic [23:0] GAP_LAST = 24'(IDLE_TIMEOUT - 1);
  localparam logic [15:0] RD_LAST  = 16'(RD_TIMEOUT - 1);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_GET_ADDR = 3'd1,
    ST_GET_DATA = 3'd2,
    ST_RD_WAIT  = 3'd3,
    ST_SEND     = 3'd4
  } state_t;

  state_t      state_r, state_nxt_s;
  logic        is_write_r, is_write_nxt_s;
  logic [23:0] gap_r, gap_nxt_s;
  logic [15:0] rd_cnt_r, rd_cnt_nxt_s;
  logic [7:0]  tx_data_r, tx_data_nxt_s;
  logic        tx_valid_r, tx_valid_nxt_s;
  logic [7:0]  addr_r, addr_nxt_s;
  logic [7:0]  wdata_r, wdata_nxt_s;
  logic        we_r, we_nxt_s;
  logic        re_r, re_nxt_s;
  logic        overrun_r, overrun_nxt_s;
  logic        busy_r;
  logic        gap_expired_s;
  logic        rd_expired_s;

  assign gap_expired_s = (gap_r == GAP_LAST);
  assign rd_expired_s  = (rd_cnt_r == RD_LAST);

  // State and registered-output register with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      is_write_r <= 1'b0;
      gap_r      <= 24'd0;
      rd_cnt_r   <= 16'd0;
      tx_data_r  <= 8'h00;
      tx_valid_r <= 1'b0;
      addr_r     <= 8'h00;
      wdata_r    <= 8'h00;
      we_r       <= 1'b0;
      re_r       <= 1'b0;
      overrun_r  <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      is_write_r <= is_write_nxt_s;
      gap_r      <= gap_nxt_s;
      rd_cnt_r   <= rd_cnt_nxt_s;
      tx_data_r  <= tx_data_nxt_s;
      tx_valid_r <= tx_valid_nxt_s;
      addr_r     <= addr_nxt_s;
      wdata_r    <= wdata_nxt_s;
      we_r       <= we_nxt_s;
      re_r       <= re_nxt_s;
      overrun_r  <= overrun_nxt_s;
      busy_r     <= (state_nxt_s != ST_IDLE);
    end
  end

  // Next-state logic. A fresh byte always takes priority over a gap timeout.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (rx_data_fresh) begin
          if ((rx_data == CMD_WR) || (rx_data == CMD_RD)) begin
            state_nxt_s = ST_GET_ADDR;
          end else begin
            state_nxt_s = ST_SEND;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_GET_ADDR: begin
        if (rx_data_fresh) begin
          state_nxt_s = is_write_r ? ST_GET_DATA : ST_RD_WAIT;
        end else if (gap_expired_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_GET_ADDR;
        end
      end
      ST_GET_DATA: begin
        if (rx_data_fresh) begin
          state_nxt_s = ST_SEND;
        end else if (gap_expired_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_GET_DATA;
        end
      end
      ST_RD_WAIT: begin
        if (reg_rdy || rd_expired_s) begin
          state_nxt_s = ST_SEND;
        end else begin
          state_nxt_s = ST_RD_WAIT;
        end
      end
      ST_SEND: begin
        if (tx_data_ack) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_SEND;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Next values of the registered outputs, timers and command latch.
  always_comb begin
    is_write_nxt_s = is_write_r;
    gap_nxt_s      = gap_r;
    rd_cnt_nxt_s   = rd_cnt_r;
    tx_data_nxt_s  = tx_data_r;
    tx_valid_nxt_s = tx_valid_r;
    addr_nxt_s     = addr_r;
    wdata_nxt_s    = wdata_r;
    we_nxt_s       = 1'b0;
    re_nxt_s       = 1'b0;
    overrun_nxt_s  = overrun_r;
    case (state_r)
      ST_IDLE: begin
        if (rx_data_fresh) begin
          if ((rx_data == CMD_WR) || (rx_data == CMD_RD)) begin
            is_write_nxt_s = (rx_data == CMD_WR);
            gap_nxt_s      = 24'd0;
          end else begin
            tx_data_nxt_s  = RSP_UNK;
            tx_valid_nxt_s = 1'b1;
          end
        end else begin
          gap_nxt_s = 24'd0;
        end
      end
      ST_GET_ADDR: begin
        if (rx_data_fresh) begin
          // Command codes here are plain address values; no resync.
          addr_nxt_s = rx_data;
          if (is_write_r) begin
            gap_nxt_s = 24'd0;
          end else begin
            re_nxt_s     = 1'b1;
            rd_cnt_nxt_s = 16'd0;
          end
        end else if (gap_expired_s) begin
          gap_nxt_s = 24'd0;
        end else begin
          gap_nxt_s = gap_r + 24'd1;
        end
      end
      ST_GET_DATA: begin
        if (rx_data_fresh) begin
          wdata_nxt_s    = rx_data;
          we_nxt_s       = 1'b1;
          tx_data_nxt_s  = RSP_OK;
          tx_valid_nxt_s = 1'b1;
        end else if (gap_expired_s) begin
          gap_nxt_s = 24'd0;
        end else begin
          gap_nxt_s = gap_r + 24'd1;
        end
      end
      ST_RD_WAIT: begin
        if (rx_data_fresh) begin
          overrun_nxt_s = 1'b1;
        end else begin
          overrun_nxt_s = overrun_r;
        end
        // reg_rdy is sampled in the reg_re cycle too, so a zero-wait slave works.
        if (reg_rdy) begin
          tx_data_nxt_s  = reg_rdata;
          tx_valid_nxt_s = 1'b1;
        end else if (rd_expired_s) begin
          tx_data_nxt_s  = RSP_TO;
          tx_valid_nxt_s = 1'b1;
        end else begin
          rd_cnt_nxt_s = rd_cnt_r + 16'd1;
        end
      end
      ST_SEND: begin
        if (rx_data_fresh) begin
          overrun_nxt_s = 1'b1;
        end else begin
          overrun_nxt_s = overrun_r;
        end
        if (tx_data_ack) begin
          tx_valid_nxt_s = 1'b0;
        end else begin
          tx_valid_nxt_s = 1'b1;
        end
      end
      default: begin
        tx_valid_nxt_s = 1'b0;
      end
    endcase
  end

  assign tx_data       = tx_data_r;
  assign tx_data_valid = tx_valid_r;
  assign reg_addr      = addr_r;
  assign reg_wdata     = wdata_r;
  assign reg_we        = we_r;
  assign reg_re        = re_r;
  assign busy          = busy_r;
  assign cmd_overrun   = overrun_r;

endmodule

// File: tb/tb_uart_cmd_responder.sv
// Directed bench for uart_cmd_responder (IDLE_TIMEOUT=100, RD_TIMEOUT=4).
// Inputs change and outputs are sampled 1 ns after each rising clock edge.
module tb_uart_cmd_responder;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_data_fresh;
  logic [7:0] tx_data;
  logic       tx_data_valid;
  logic       tx_data_ack;
  logic [7:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_we;
  logic       reg_re;
  logic [7:0] reg_rdata;
  logic       reg_rdy;
  logic       busy;
  logic       cmd_overrun;

  int n_cmp = 0;
  int n_bad = 0;
  int we_cnt = 0;
  int re_cnt = 0;
  int we_base;
  int re_base;

  uart_cmd_responder #(.IDLE_TIMEOUT(100), .RD_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .rx_data(rx_data), .rx_data_fresh(rx_data_fresh),
    .tx_data(tx_data), .tx_data_valid(tx_data_valid), .tx_data_ack(tx_data_ack),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_we(reg_we), .reg_re(reg_re),
    .reg_rdata(reg_rdata), .reg_rdy(reg_rdy),
    .busy(busy), .cmd_overrun(cmd_overrun)
  );

  always #5 clk = ~clk;

  // Strobe counters.
  always @(posedge clk) begin
    if (reg_we) we_cnt <= we_cnt + 1;
    if (reg_re) re_cnt <= re_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_data_fresh = 1'b1;
    tick();
    rx_data_fresh = 1'b0;
  endtask

  task automatic do_ack();
    tx_data_ack = 1'b1;
    tick();
    tx_data_ack = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    rx_data = 8'h00;
    rx_data_fresh = 1'b0;
    tx_data_ack = 1'b0;
    reg_rdata = 8'h00;
    reg_rdy = 1'b0;
    tick();
    tick();
    check("rst_tx_data", tx_data, 8'h00);
    check("rst_valid", tx_data_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_we_re", {reg_we, reg_re}, 2'b00);
    check("rst_overrun", cmd_overrun, 1'b0);
    rst = 1'b0;
    tick();

    // Write 0x57 0x12 0xA5
    we_base = we_cnt;
    send_byte(8'h57);
    check("wr_busy", busy, 1'b1);
    send_byte(8'h12);
    check("wr_no_we_yet", reg_we, 1'b0);
    send_byte(8'hA5);
    check("wr_we", reg_we, 1'b1);
    check("wr_addr", reg_addr, 8'h12);
    check("wr_wdata", reg_wdata, 8'hA5);
    check("wr_valid", tx_data_valid, 1'b1);
    check("wr_tx", tx_data, 8'h4B);
    tick();
    check("wr_we_one_cycle", reg_we, 1'b0);
    check("wr_valid_held", tx_data_valid, 1'b1);
    check("wr_tx_held", tx_data, 8'h4B);
    do_ack();
    check("wr_valid_drop", tx_data_valid, 1'b0);
    check("wr_busy_idle", busy, 1'b0);
    check("wr_we_count", we_cnt - we_base, 1);

    // Write with command codes as address/data
    send_byte(8'h57);
    send_byte(8'h57);
    send_byte(8'h52);
    check("wrcc_addr", reg_addr, 8'h57);
    check("wrcc_wdata", reg_wdata, 8'h52);
    check("wrcc_tx", tx_data, 8'h4B);
    do_ack();

    // Read 0x34, slave ready in RD_WAIT cycle 3
    re_base = re_cnt;
    send_byte(8'h52);
    send_byte(8'h34);
    check("rd_re", reg_re, 1'b1);
    check("rd_addr", reg_addr, 8'h34);
    tick();
    check("rd_re_one_cycle", reg_re, 1'b0);
    tick();
    tick();
    check("rd_not_yet", tx_data_valid, 1'b0);
    reg_rdy = 1'b1;
    reg_rdata = 8'hC3;
    tick();
    reg_rdy = 1'b0;
    check("rd_valid", tx_data_valid, 1'b1);
    check("rd_tx", tx_data, 8'hC3);
    check("rd_re_count", re_cnt - re_base, 1);
    do_ack();
    check("rd_busy_idle", busy, 1'b0);

    // Read timeout after exactly 4 RD_WAIT cycles
    send_byte(8'h52);
    send_byte(8'h01);
    tick();
    tick();
    tick();
    check("to_not_yet", tx_data_valid, 1'b0);
    tick();
    check("to_valid", tx_data_valid, 1'b1);
    check("to_tx", tx_data, 8'h54);
    do_ack();

    // Unknown command, then zero-wait read
    we_base = we_cnt;
    re_base = re_cnt;
    send_byte(8'h41);
    check("unk_valid", tx_data_valid, 1'b1);
    check("unk_tx", tx_data, 8'h3F);
    check("unk_no_strobe", (we_cnt - we_base) + (re_cnt - re_base), 0);
    do_ack();
    send_byte(8'h52);
    send_byte(8'h02);
    check("zw_re", reg_re, 1'b1);
    reg_rdy = 1'b1;
    reg_rdata = 8'h5A;
    tick();
    reg_rdy = 1'b0;
    check("zw_valid", tx_data_valid, 1'b1);
    check("zw_tx", tx_data, 8'h5A);
    do_ack();

    // Gap timeout mid-write, then read of the same address
    we_base = we_cnt;
    send_byte(8'h57);
    send_byte(8'h10);
    repeat (99) tick();
    check("gap_still_busy", busy, 1'b1);
    tick();
    check("gap_dropped", busy, 1'b0);
    send_byte(8'h52);
    send_byte(8'h10);
    check("gap_rd_re", reg_re, 1'b1);
    check("gap_rd_addr", reg_addr, 8'h10);
    reg_rdy = 1'b1;
    reg_rdata = 8'h77;
    tick();
    reg_rdy = 1'b0;
    check("gap_rd_tx", tx_data, 8'h77);
    check("gap_no_we", we_cnt - we_base, 0);
    check("gap_no_overrun", cmd_overrun, 1'b0);
    do_ack();

    // Overrun while ack withheld, then async reset mid-SEND
    send_byte(8'h41);
    send_byte(8'h55);
    check("ovr_flag", cmd_overrun, 1'b1);
    check("ovr_tx_held", tx_data, 8'h3F);
    check("ovr_valid_held", tx_data_valid, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check("arst_valid", tx_data_valid, 1'b0);
    check("arst_overrun", cmd_overrun, 1'b0);
    check("arst_tx", tx_data, 8'h00);
    check("arst_busy", busy, 1'b0);
    tick();
    rst = 1'b0;
    tick();
    check("post_rst_idle", busy, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_cmd_responder.md
Name: uart_cmd_responder

Overview:
- Command responder at the far end of the host serial link. Host (PC) is the initiator; this block is the responder.
- Consumes the received byte stream (rx_data/rx_data_fresh) of the existing UART receiver and parses single-byte read/write commands.
- Executes each command on a simple 8-bit register bus and returns exactly one response byte through the existing UART transmitter handshake (tx_data/tx_data_valid/tx_data_ack).

Parameters:
- IDLE_TIMEOUT, 5_000_000, max clk cycles allowed between bytes of one command before the partial command is dropped (1..2^24-1).
- RD_TIMEOUT, 256, max clk cycles to wait for reg_rdy after a bus read (1..65535).

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- rx_data  in  8  received byte; valid when rx_data_fresh=1
- rx_data_fresh  in  1  one-cycle pulse per received byte
- tx_data  out  8  response byte to transmitter
- tx_data_valid  out  1  response request; held until acknowledged
- tx_data_ack  in  1  one-cycle pulse from transmitter: byte accepted
- reg_addr  out  8  register bus address
- reg_wdata  out  8  register bus write data
- reg_we  out  1  one-cycle write strobe
- reg_re  out  1  one-cycle read strobe
- reg_rdata  in  8  read data; valid when reg_rdy=1
- reg_rdy  in  1  read data valid
- busy  out  1  1 whenever state != IDLE
- cmd_overrun  out  1  sticky: a byte arrived while not accepting; cleared only by rst

Behaviour:
- Reset (async, takes effect immediately): state=IDLE; all outputs 0; tx_data=0x00; timers=0. A reset mid-command or mid-send drops everything, and reg_we/reg_re/tx_data_valid fall at once.
- Protocol:
  - Write: 0x57 'W', addr, data. Response 0x4B 'K'.
  - Read: 0x52 'R', addr. Response is the read byte, or 0x54 'T' on bus timeout.
  - Any other first byte: response 0x3F '?'.
- State IDLE, on rx_data_fresh:
  - 0x57 or 0x52: latch command, go to GET_ADDR, clear gap timer.
  - Any other byte: tx_data<=0x3F, tx_data_valid<=1, go to SEND.
- State GET_ADDR, on fresh byte: reg_addr<=rx_data.
  - Write command: go to GET_DATA, clear gap timer.
  - Read command: reg_re<=1, clear read timer, go to RD_WAIT.
- State GET_DATA, on fresh byte: reg_wdata<=rx_data, reg_we<=1, tx_data<=0x4B, tx_data_valid<=1, go to SEND. reg_we and tx_data_valid both rise one cycle after the fresh pulse; reg_we lasts exactly one cycle.
- Gap timer (GET_ADDR and GET_DATA): increments each cycle with no fresh byte. On reaching IDLE_TIMEOUT-1, return to IDLE. No response, no bus access, cmd_overrun unchanged.
- State RD_WAIT:
  - reg_re is high only in the first RD_WAIT cycle.
  - reg_rdy is sampled every RD_WAIT cycle, including the reg_re cycle (zero-wait slave supported).
  - reg_rdy=1: tx_data<=reg_rdata, tx_data_valid<=1, go to SEND.
  - No reg_rdy within RD_TIMEOUT cycles (cycles 0..RD_TIMEOUT-1 counted from the reg_re cycle): tx_data<=0x54, go to SEND.
- State SEND:
  - tx_data and tx_data_valid held stable until tx_data_ack=1.
  - On the edge that samples ack: tx_data_valid<=0, go to IDLE.
  - Next command byte is accepted from the following cycle.
- Bytes arriving in RD_WAIT or SEND are discarded and set cmd_overrun<=1.
- Simultaneous fresh byte and gap-timer expiry: the byte wins (it is processed; no timeout).
- Command and address bytes of value 0x57/0x52 in address or data position are treated as data (no resync on command codes).
- Latency from last command byte's fresh pulse to tx_data_valid rising:
  - Write and unknown command: 1 cycle.
  - Read: 2 cycles plus slave wait.

Test Plan:
- Write: bytes 0x57, 0x12, 0xA5 -> one reg_we pulse with reg_addr=0x12, reg_wdata=0xA5; tx_data=0x4B valid until ack; busy returns to 0.
- Read with 3-cycle slave delay: 0x52, 0x34; reg_rdy+reg_rdata=0xC3 on 3rd cycle after reg_re -> single reg_re pulse with reg_addr=0x34, tx_data=0xC3.
- Read timeout, RD_TIMEOUT=4: 0x52, 0x01; reg_rdy held 0 -> tx_data=0x54 after exactly 4 RD_WAIT cycles.
- Unknown command 0x41 -> tx_data=0x3F, no reg_we/reg_re; then 0x52, 0x02 with zero-wait slave -> normal read response.
- Gap timeout, IDLE_TIMEOUT=100: 0x57, 0x10, then silence 100 cycles, then 0x52, 0x10 -> no write strobe; read of 0x10 executes.
- Overrun/reset: byte sent while tx_data_ack withheld -> cmd_overrun=1, byte ignored. Then assert rst mid-SEND -> tx_data_valid and cmd_overrun drop to 0 without waiting for a clk edge.
